// File: rtl/alu_issue.sv
// Command-side issuer for an 8-bit combinational ALU: register-file operands,
// one-cycle ALU round trip, writeback, response channel and independent flag check.
module alu_issue #(
   parameter int REG_AW    = 2,
   parameter int ERR_CNT_W = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 cmd_valid,
   output logic                 cmd_ready,
   input  logic [3:0]           cmd_op,
   input  logic [REG_AW-1:0]    cmd_dst,
   input  logic [REG_AW-1:0]    cmd_src_a,
   input  logic [REG_AW-1:0]    cmd_src_b,
   input  logic [7:0]           cmd_imm,
   output logic [3:0]           alu_opcode,
   output logic [7:0]           alu_a,
   output logic [7:0]           alu_b,
   input  logic [7:0]           alu_y,
   input  logic                 alu_zero,
   input  logic                 alu_overflow,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [7:0]           rsp_data,
   output logic                 rsp_zero,
   output logic                 rsp_ovf,
   output logic                 rsp_err,
   output logic                 rsp_chk,
   output logic [ERR_CNT_W-1:0] err_cnt,
   input  logic [REG_AW-1:0]    dbg_sel,
   output logic [7:0]           dbg_data
);

   localparam int NREG = 1 << REG_AW;

   // ALU encoding for the ops whose flags or operands need special handling
   localparam logic [3:0] OP_ADD  = 4'h0;
   localparam logic [3:0] OP_SUB  = 4'h1;
   localparam logic [3:0] OP_DIV  = 4'h3;
   localparam logic [3:0] OP_LOAD = 4'hF;

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t            state, state_nxt;
   logic [7:0]        regs [NREG];
   logic [REG_AW-1:0] dst_q;

   logic accept, op_alu, div0, issue, load, reject;
   logic exp_zero, exp_ovf, mismatch;

   assign cmd_ready = (state == IDLE);
   assign accept    = cmd_valid & cmd_ready;
   assign op_alu    = (cmd_op <= 4'd9);
   assign div0      = (cmd_op == OP_DIV) && (regs[cmd_src_b] == 8'h00);
   assign issue     = accept & op_alu & ~div0;
   assign load      = accept & (cmd_op == OP_LOAD);
   assign reject    = accept & ~issue & ~load;
   assign dbg_data  = regs[dbg_sel];

   // Flags recomputed from the issued operands and the returned result
   always_comb begin
      exp_zero = (alu_y == 8'h00);
      exp_ovf  = 1'b0;
      case (alu_opcode)
         OP_ADD:  exp_ovf = (alu_a[7] == alu_b[7]) && (alu_y[7] != alu_a[7]);
         OP_SUB:  exp_ovf = (alu_a[7] != alu_b[7]) && (alu_y[7] != alu_a[7]);
         default: exp_ovf = 1'b0;
      endcase
      mismatch = (exp_zero != alu_zero) | (exp_ovf != alu_overflow);
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (issue)       state_nxt = EXEC;
            else if (accept) state_nxt = RESP;
         end
         EXEC:    state_nxt = RESP;
         RESP:    if (rsp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) regs[i] <= 8'h00;
         dst_q      <= '0;
         alu_opcode <= 4'h0;
         alu_a      <= 8'h00;
         alu_b      <= 8'h00;
         rsp_valid  <= 1'b0;
         rsp_data   <= 8'h00;
         rsp_zero   <= 1'b0;
         rsp_ovf    <= 1'b0;
         rsp_err    <= 1'b0;
         rsp_chk    <= 1'b0;
         err_cnt    <= '0;
      end else begin
         // Operands are read at acceptance; src==dst sees the old value
         if (issue) begin
            alu_opcode <= cmd_op;
            alu_a      <= regs[cmd_src_a];
            alu_b      <= regs[cmd_src_b];
            dst_q      <= cmd_dst;
         end
         if (load) begin
            regs[cmd_dst] <= cmd_imm;
            rsp_valid     <= 1'b1;
            rsp_data      <= cmd_imm;
            rsp_zero      <= 1'b0;
            rsp_ovf       <= 1'b0;
            rsp_err       <= 1'b0;
            rsp_chk       <= 1'b0;
         end
         if (reject) begin
            rsp_valid <= 1'b1;
            rsp_data  <= 8'h00;
            rsp_zero  <= 1'b0;
            rsp_ovf   <= 1'b0;
            rsp_err   <= 1'b1;
            rsp_chk   <= 1'b0;
         end
         if (state == EXEC) begin
            regs[dst_q] <= alu_y;
            rsp_valid   <= 1'b1;
            rsp_data    <= alu_y;
            rsp_zero    <= alu_zero;
            rsp_ovf     <= alu_overflow;
            rsp_err     <= 1'b0;
            rsp_chk     <= mismatch;
            if (mismatch && (err_cnt != '1)) err_cnt <= err_cnt + ERR_CNT_W'(1);
         end
         if ((state == RESP) && rsp_ready) rsp_valid <= 1'b0;
      end
   end

endmodule
